// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; queued characters stream out back-to-back.
// Define UART_TX_PARITY_EN to compile in a parity bit after the data bits.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
    localparam logic       ODD_BIT  = 1'(PARITY_ODD);
`endif
    localparam logic [2:0] StStop   = 3'd4;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_fifo: illegal parameter combination");
    end

    // FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign overflow = wr_en & full;
    assign push     = wr_en & ~full;
    assign head     = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Serialiser
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, line;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign tick = (baud_q == LAST_TICK);
    assign busy = (state_q != StIdle);
    assign tx   = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        line    = 1'b1;
        if (state_q != StIdle) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                line = 1'b0;
                if (tick) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                line = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                line = par_q;
                if (tick) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when data is waiting
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            shift_d = head;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        par_d = par_q;
        if (pop) begin
            par_d = (^head) ^ ODD_BIT;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= line;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
